// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the conv-layer input streamer.
package conv_stream_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  localparam int unsigned LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 as a bit mask over state bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/conv_stream_skid.sv
// Two-entry valid/ready output buffer (output register + skid register) with
// occupancy and a read credit that accounts for the in-flight word and this cycle's pop.
module conv_stream_skid #(
  parameter int unsigned T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] in_data,
  input  logic         in_valid,
  input  logic         load_ok,
  output logic [T-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy,
  output logic         credit
);

  logic [T-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [T-1:0] skid_data_q, skid_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic         pop;
  logic [1:0]   fill;

  assign pop       = out_valid_q && out_ready;
  assign occupancy = {out_valid_q & skid_valid_q, out_valid_q ^ skid_valid_q};
  assign fill      = occupancy + {1'b0, in_valid} - {1'b0, pop};
  assign credit    = (fill < 2'd2);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid;
        skid_data_d  = in_data;
      end else if (in_valid && load_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        // Throttled arrival parks in the skid so the output slot stays empty
        out_valid_d  = 1'b0;
        skid_valid_d = in_valid;
        skid_data_d  = in_data;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/conv_input_streamer.sv
// Buffers one NUMVALS-word frame and plays it out on a valid/ready stream.
// Optional STREAM_THROTTLE_EN inserts LFSR-driven bubbles for protocol stress.
import conv_stream_pkg::*;

module conv_input_streamer #(
  parameter int unsigned T         = 16,
  parameter int unsigned NUMVALS   = 9984,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned ADDRW    = $clog2(NUMVALS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [T-1:0]     wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [T-1:0]     m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x
);

  localparam logic [ADDRW:0]   NUMV    = (ADDRW+1)'(NUMVALS);
  localparam logic [ADDRW:0]   PTR_ONE = (ADDRW+1)'(1);
  localparam logic [ADDRW-1:0] CNT_ONE = ADDRW'(1);
  localparam logic [ADDRW-1:0] LAST    = ADDRW'(NUMVALS - 1);

  state_e           state_q, state_d;
  logic [ADDRW:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDRW-1:0] tx_cnt_q, tx_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic [T-1:0]     rd_data_q;
  logic [T-1:0]     mem [NUMVALS];
  logic             rd_en, wr_ok, xfer, credit, load_ok;
  logic [1:0]       occ_unused;

  assign xfer  = m_valid_x && m_ready_x;
  assign wr_ok = wr_en && (state_q != RUN) && ({1'b0, wr_addr} < NUMV);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_ptr_q[ADDRW-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    tx_cnt_d = tx_cnt_q;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          rd_ptr_d = '0;
          tx_cnt_d = '0;
        end
      end
      RUN: begin
        // Credit covers the read in flight plus a pop this cycle, keeping
        // full rate without ever exceeding two words stored or pending
        rd_en = (rd_ptr_q < NUMV) && credit;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (xfer) begin
          if (tx_cnt_q == LAST) state_d = DONE;
          else                  tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_vld_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      tx_cnt_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      tx_cnt_q <= tx_cnt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

`ifdef STREAM_THROTTLE_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign lfsr_d  = lfsr_next(lfsr_q);
  assign load_ok = lfsr_q[0];

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  localparam logic [15:0] seed_unused = LFSR_SEED;
  assign load_ok = 1'b1;
`endif

  conv_stream_skid #(
    .T(T)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (rd_data_q),
    .in_valid  (rd_vld_q),
    .load_ok   (load_ok),
    .out_data  (m_data_out_x),
    .out_valid (m_valid_x),
    .out_ready (m_ready_x),
    .occupancy (occ_unused),
    .credit    (credit)
  );

endmodule

// File: tb/tb_conv_input_streamer.sv
// Directed bench for conv_input_streamer (NUMVALS=16) with a scoreboard of expected words.
module tb_conv_input_streamer;

  localparam int unsigned T     = 16;
  localparam int unsigned NV    = 16;
  localparam int unsigned ADDRW = $clog2(NV);

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [T-1:0]     wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [T-1:0]     m_data_out_x;
  logic             m_valid_x;
  logic             m_ready_x;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rx_total = 0;
  int          base;
  logic [T-1:0] model [NV];
  logic [T-1:0] sb [$];
  logic         prev_stall = 1'b0;
  logic [T-1:0] prev_data = '0;

  conv_input_streamer #(
    .T(T),
    .NUMVALS(NV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [T-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDRW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_frame();
    for (int i = 0; i < int'(NV); i++) sb.push_back(model[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (done === 1'b1) break;
      tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid_x), 32'd1);
        check("hold_data", 32'(m_data_out_x), 32'(prev_data));
      end
      if (m_valid_x && m_ready_x) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_extra observed=%0h expected=no_more_words", m_data_out_x);
        end else begin
          check("stream_data", 32'(m_data_out_x), 32'(sb.pop_front()));
        end
        rx_total++;
      end
      prev_stall = m_valid_x && !m_ready_x;
      prev_data  = m_data_out_x;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; m_ready_x = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(m_valid_x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < int'(NV); i++) begin
      model[i] = T'(i);
      write_word(i, T'(i));
    end

    // Test 1: full rate, latency and done/busy timing
    m_ready_x = 1'b1;
    start_frame();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_lat_k0", 32'(m_valid_x), 32'd0);
    tick();
    check("t1_lat_k1", 32'(m_valid_x), 32'd0);
    tick();
    check("t1_lat_k2", 32'(m_valid_x), 32'd1);
    check("t1_first", 32'(m_data_out_x), 32'd0);
    for (int i = 1; i < int'(NV); i++) begin
      tick();
      check("t1_b2b", 32'(m_valid_x), 32'd1);
    end
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Test 2: random backpressure
    start_frame();
    for (int c = 0; c < 400; c++) begin
      m_ready_x = 1'($urandom_range(0, 1));
      tick();
      if (done === 1'b1) break;
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    m_ready_x = 1'b1;
    tick();

    // Test 3: long stall on word 5, then back-to-back resume
    base = rx_total;
    start_frame();
    for (int c = 0; c < 60; c++) begin
      if (rx_total - base == 5) break;
      tick();
    end
    check("t3_reach5", 32'(rx_total - base), 32'd5);
    m_ready_x = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check("t3_stall_valid", 32'(m_valid_x), 32'd1);
      check("t3_stall_data", 32'(m_data_out_x), 32'd5);
      tick();
    end
    m_ready_x = 1'b1;
    tick();
    for (int i = 6; i < int'(NV); i++) begin
      check("t3_resume_b2b", 32'(m_valid_x), 32'd1);
      tick();
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Test 4: start and write while busy are ignored; rewrite after done takes effect
    start_frame();
    tick();
    wr_en = 1'b1; wr_addr = ADDRW'(3); wr_data = 16'hBEEF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("t4_busy_hold", 32'(busy), 32'd1);
    wait_done("t4_done1");
    check("t4_sb_empty1", 32'(sb.size()), 32'd0);
    tick();
    tick();
    check("t4_no_relaunch", 32'(busy), 32'd0);
    model[3] = 16'hBEEF;
    write_word(3, 16'hBEEF);
    start_frame();
    wait_done("t4_done2");
    check("t4_sb_empty2", 32'(sb.size()), 32'd0);
    tick();

    // Test 5: reset mid-frame, restart from word 0
    base = rx_total;
    start_frame();
    for (int c = 0; c < 60; c++) begin
      if (rx_total - base == 7) break;
      tick();
    end
    check("t5_reach7", 32'(rx_total - base), 32'd7);
    m_ready_x = 1'b0;
    reset = 1'b0;
    tick();
    check("t5_rst_valid", 32'(m_valid_x), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    sb.delete();
    tick();
    m_ready_x = 1'b1;
    start_frame();
    tick();
    tick();
    check("t5_first_valid", 32'(m_valid_x), 32'd1);
    check("t5_first_word", 32'(m_data_out_x), 32'(model[0]));
    wait_done("t5_done");
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
